// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF challenge/response path:
// challenge length, LFSR taps and sequencer states.
package puf_pkg;

  localparam int C_LEN_DEF = 8;

  // x^8 + x^6 + x^5 + x^4 + 1, Galois form, right shift
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    DECIDE,
    OUTPUT
  } state_e;

endpackage

// File: rtl/challenge_lfsr.sv
// Challenge generator: Galois LFSR, loadable with a seed (0 -> 1).
// Ports: load/seed reload, step advances once, value is the register.
module challenge_lfsr
  import puf_pkg::*;
#(
  parameter int W = C_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);

  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      // all-zero is the lock-up state of the LFSR
      val_d = (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      val_d = (val_q >> 1) ^ (val_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign value = val_q;

endmodule

// File: rtl/puf_crp_controller.sv
// PUF challenge/response sequencer: launches each challenge NUM_EVALS
// times, majority-votes the synced arbiter bit, packs RESP_WIDTH bits
// and hands the word out on resp_valid/resp_ready.
module puf_crp_controller
  import puf_pkg::*;
#(
  parameter int C_LENGTH      = C_LEN_DEF,
  parameter int RESP_WIDTH    = 8,
  parameter int NUM_EVALS     = 5,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [C_LENGTH-1:0]   seed,
  output logic [C_LENGTH-1:0]   challenge,
  output logic                  launch,
  input  logic                  response_in,
  output logic                  busy,
  output logic [RESP_WIDTH-1:0] resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready
);

  localparam int CW = $clog2(NUM_EVALS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int BW = (RESP_WIDTH > 1) ? $clog2(RESP_WIDTH) : 1;

  if (NUM_EVALS % 2 == 0) begin : g_chk_evals
    $error("NUM_EVALS must be odd");
  end
  if (SETTLE_CYCLES < 3) begin : g_chk_settle
    $error("SETTLE_CYCLES must be >= 3");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         ones_q, ones_d;
  logic [CW-1:0]         eval_q, eval_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d;
  logic                  sync1_q, sync2_q;
  logic                  launch_q, busy_q, valid_q;
  logic                  lfsr_load, lfsr_step;

  challenge_lfsr #(.W(C_LENGTH)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .value (challenge)
  );

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    eval_d    = eval_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    resp_d    = resp_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          ones_d    = '0;
          eval_d    = '0;
          bit_d     = '0;
          resp_d    = '0;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
        else cnt_d = cnt_q + SW'(1);
      end
      SAMPLE: begin
        ones_d = ones_q + CW'(sync2_q);
        eval_d = eval_q + CW'(1);
        if (eval_d < CW'(NUM_EVALS)) state_d = LAUNCH;
        else state_d = DECIDE;
      end
      DECIDE: begin
        resp_d[bit_q] = (ones_q > CW'(NUM_EVALS / 2));
        lfsr_step     = 1'b1;
        ones_d        = '0;
        eval_d        = '0;
        bit_d         = bit_q + BW'(1);
        if (bit_q == BW'(RESP_WIDTH - 1)) state_d = OUTPUT;
        else state_d = LAUNCH;
      end
      OUTPUT: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      eval_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      resp_q   <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      eval_q   <= eval_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      resp_q   <= resp_d;
      sync1_q  <= response_in;
      sync2_q  <= sync1_q;
      // outputs registered from next state so they track state_q
      launch_q <= (state_d == LAUNCH);
      busy_q   <= (state_d != IDLE);
      valid_q  <= (state_d == OUTPUT);
    end
  end

  assign launch     = launch_q;
  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_data  = resp_q;

endmodule
